// File: rtl/qei_multi.sv
// Multi-channel quadrature encoder interface.
// Each channel synchronises and glitch-filters A/B/Z, decodes A/B at 4x into a wrapping
// position counter, captures or zeroes the position on the index edge, flags illegal
// A/B jumps, and measures signed edge counts over a shared velocity window.
module qei_multi #(
    parameter int unsigned N_CH     = 3,
    parameter int unsigned CNT_W    = 32,
    parameter int unsigned FILT_DIV = 4,
    parameter int unsigned FILT_LEN = 3,
    parameter int unsigned VEL_WIN  = 50000,
    parameter int unsigned VEL_W    = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_CH-1:0]         enc_a,
    input  logic [N_CH-1:0]         enc_b,
    input  logic [N_CH-1:0]         enc_z,
    input  logic [N_CH-1:0]         clr,
    input  logic [N_CH-1:0]         idx_clr_en,
    input  logic [N_CH-1:0]         dir_inv,
    output logic [N_CH*CNT_W-1:0]   pos,
    output logic [N_CH*CNT_W-1:0]   idx_pos,
    output logic [N_CH-1:0]         idx_seen,
    output logic [N_CH-1:0]         err,
    output logic [N_CH*VEL_W-1:0]   vel,
    output logic                    vel_valid
);

    localparam int unsigned NB = 3 * N_CH;
    localparam int unsigned PW = (FILT_DIV > 1) ? $clog2(FILT_DIV) : 1;
    localparam int unsigned FW = $clog2(FILT_LEN + 1);
    localparam int unsigned WW = (VEL_WIN > 1) ? $clog2(VEL_WIN) : 1;
    // Accumulator wide enough for a full window of edges plus saturation headroom.
    localparam int unsigned AW = (($clog2(VEL_WIN + 1) > VEL_W) ? $clog2(VEL_WIN + 1) : VEL_W) + 2;
    localparam logic signed [AW-1:0] VMax = AW'((2 ** (VEL_W - 1)) - 1);
    localparam logic signed [AW-1:0] VMin = -VMax;

    // Bit layout of all filtered vectors: [A ch0..chN-1, B ch0.., Z ch0..].
    logic [NB-1:0] raw, sync1_q, sync2_q, filt_q, filt_d, filt_prev_q;
    logic [FW-1:0] fcnt_q [NB];
    logic [FW-1:0] fcnt_d [NB];
    logic [PW-1:0] pre_q;
    logic          strobe;

    logic [N_CH-1:0] inc, dec, ill, zrise;

    logic [CNT_W-1:0]       pos_q [N_CH];
    logic [CNT_W-1:0]       pos_d [N_CH];
    logic [CNT_W-1:0]       idx_pos_q [N_CH];
    logic [CNT_W-1:0]       idx_pos_d [N_CH];
    logic [N_CH-1:0]        idx_seen_q, idx_seen_d, err_q, err_d;
    logic [WW-1:0]          win_q;
    logic                   win_end;
    logic                   vel_valid_q;
    logic signed [AW-1:0]   acc_q [N_CH];
    logic signed [AW-1:0]   acc_d [N_CH];
    logic signed [AW-1:0]   sum [N_CH];
    logic [VEL_W-1:0]       vel_q [N_CH];
    logic [VEL_W-1:0]       vel_d [N_CH];

    assign raw     = {enc_z, enc_b, enc_a};
    assign strobe  = (pre_q == PW'(FILT_DIV - 1));
    assign win_end = (win_q == WW'(VEL_WIN - 1));

    // Two-flop synchroniser, shared filter prescaler and velocity window counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            pre_q       <= '0;
            win_q       <= '0;
            vel_valid_q <= 1'b0;
        end else begin
            sync1_q     <= raw;
            sync2_q     <= sync1_q;
            pre_q       <= strobe ? '0 : pre_q + 1'b1;
            win_q       <= win_end ? '0 : win_q + 1'b1;
            vel_valid_q <= win_end;
        end
    end

    // Filter: count consecutive strobed samples that differ from the accepted level.
    always_comb begin
        filt_d = filt_q;
        for (int i = 0; i < NB; i++) begin
            fcnt_d[i] = fcnt_q[i];
            if (strobe) begin
                if (sync2_q[i] != filt_q[i]) begin
                    if (fcnt_q[i] == FW'(FILT_LEN - 1)) begin
                        filt_d[i] = ~filt_q[i];
                        fcnt_d[i] = '0;
                    end else begin
                        fcnt_d[i] = fcnt_q[i] + 1'b1;
                    end
                end else begin
                    fcnt_d[i] = '0;
                end
            end
        end
    end

    // Filter state and previous filtered level for edge/transition detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            filt_q      <= '0;
            filt_prev_q <= '0;
            for (int i = 0; i < NB; i++) fcnt_q[i] <= '0;
        end else begin
            filt_q      <= filt_d;
            filt_prev_q <= filt_q;
            for (int i = 0; i < NB; i++) fcnt_q[i] <= fcnt_d[i];
        end
    end

    // 4x decode: map {A,B} onto a 2-bit phase (00,10,11,01 -> 0..3) and take the difference.
    always_comb begin
        for (int c = 0; c < N_CH; c++) begin
            logic [1:0] cur, prv, dif;
            cur = {filt_q[N_CH+c], filt_q[c] ^ filt_q[N_CH+c]};
            prv = {filt_prev_q[N_CH+c], filt_prev_q[c] ^ filt_prev_q[N_CH+c]};
            dif = cur - prv;
            ill[c]   = (dif == 2'b10);
            inc[c]   = dir_inv[c] ? (dif == 2'b11) : (dif == 2'b01);
            dec[c]   = dir_inv[c] ? (dif == 2'b01) : (dif == 2'b11);
            zrise[c] = filt_q[2*N_CH+c] & ~filt_prev_q[2*N_CH+c];
        end
    end

    // Position, index capture, sticky flags and velocity accumulation per channel.
    always_comb begin
        for (int c = 0; c < N_CH; c++) begin
            logic [CNT_W-1:0] delta;
            delta = inc[c] ? CNT_W'(1) : (dec[c] ? '1 : '0);
            pos_d[c]      = pos_q[c] + delta;
            idx_pos_d[c]  = idx_pos_q[c];
            idx_seen_d[c] = idx_seen_q[c];
            err_d[c]      = err_q[c];
            if (zrise[c]) begin
                idx_pos_d[c]  = pos_q[c];
                idx_seen_d[c] = 1'b1;
                if (idx_clr_en[c]) pos_d[c] = delta;
            end
            if (clr[c]) begin
                pos_d[c]      = delta;
                idx_seen_d[c] = 1'b0;
                err_d[c]      = 1'b0;
            end else if (ill[c]) begin
                err_d[c] = 1'b1;
            end

            sum[c]   = acc_q[c] + (inc[c] ? AW'(1) : (dec[c] ? '1 : '0));
            acc_d[c] = sum[c];
            vel_d[c] = vel_q[c];
            if (win_end) begin
                acc_d[c] = '0;
                if (sum[c] > VMax)      vel_d[c] = VMax[VEL_W-1:0];
                else if (sum[c] < VMin) vel_d[c] = VMin[VEL_W-1:0];
                else                    vel_d[c] = sum[c][VEL_W-1:0];
            end
        end
    end

    // Per-channel state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_seen_q <= '0;
            err_q      <= '0;
            for (int c = 0; c < N_CH; c++) begin
                pos_q[c]     <= '0;
                idx_pos_q[c] <= '0;
                acc_q[c]     <= '0;
                vel_q[c]     <= '0;
            end
        end else begin
            idx_seen_q <= idx_seen_d;
            err_q      <= err_d;
            for (int c = 0; c < N_CH; c++) begin
                pos_q[c]     <= pos_d[c];
                idx_pos_q[c] <= idx_pos_d[c];
                acc_q[c]     <= acc_d[c];
                vel_q[c]     <= vel_d[c];
            end
        end
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_out
        assign pos[c*CNT_W +: CNT_W]     = pos_q[c];
        assign idx_pos[c*CNT_W +: CNT_W] = idx_pos_q[c];
        assign vel[c*VEL_W +: VEL_W]     = vel_q[c];
    end
    assign idx_seen  = idx_seen_q;
    assign err       = err_q;
    assign vel_valid = vel_valid_q;

endmodule

// File: tb/tb_qei_multi.sv
// Bench for qei_multi: a 32-bit/16-bit-velocity instance and an 8-bit/6-bit-velocity
// instance share the same stimulus; a small encoder model supplies expected values.
module tb_qei_multi;

    localparam int N = 3;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] enc_a = '0, enc_b = '0, enc_z = '0;
    logic [N-1:0] clr = '0, idx_clr_en = '0, dir_inv = '0;

    logic [N*32-1:0] pos, idx_pos;
    logic [N-1:0]    idx_seen, err;
    logic [N*16-1:0] vel;
    logic            vel_valid;

    logic [N*8-1:0]  pos_s, idx_pos_s;
    logic [N-1:0]    idx_seen_s, err_s;
    logic [N*6-1:0]  vel_s;
    logic            vel_valid_s;

    qei_multi #(.N_CH(N), .CNT_W(32), .FILT_DIV(1), .FILT_LEN(3), .VEL_WIN(1000), .VEL_W(16))
    dut (
        .clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b), .enc_z(enc_z), .clr(clr),
        .idx_clr_en(idx_clr_en), .dir_inv(dir_inv), .pos(pos), .idx_pos(idx_pos),
        .idx_seen(idx_seen), .err(err), .vel(vel), .vel_valid(vel_valid)
    );

    qei_multi #(.N_CH(N), .CNT_W(8), .FILT_DIV(1), .FILT_LEN(3), .VEL_WIN(1000), .VEL_W(6))
    dut_s (
        .clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b), .enc_z(enc_z), .clr(clr),
        .idx_clr_en(idx_clr_en), .dir_inv(dir_inv), .pos(pos_s), .idx_pos(idx_pos_s),
        .idx_seen(idx_seen_s), .err(err_s), .vel(vel_s), .vel_valid(vel_valid_s)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Encoder model: gray phase per channel and expected position.
    int          ph[N];
    logic [31:0] mpos[N];

    string       tag_q[$];
    logic [63:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] observe(input string t);
        if (t == "pos0")    return 64'(pos[31:0]);
        if (t == "pos1")    return 64'(pos[63:32]);
        if (t == "pos2")    return 64'(pos[95:64]);
        if (t == "pos_s0")  return 64'(pos_s[7:0]);
        if (t == "err0")    return 64'(err[0]);
        if (t == "seen1")   return 64'(idx_seen[1]);
        if (t == "idxpos1") return 64'(idx_pos[63:32]);
        if (t == "vel0")    return 64'(vel[15:0]);
        if (t == "vel1")    return 64'(vel[31:16]);
        if (t == "vel_s0")  return 64'(vel_s[5:0]);
        if (t == "vv")      return 64'(vel_valid);
        return 64'hDEAD_BEEF_DEAD_BEEF;
    endfunction

    task automatic sb_push(input string t, input logic [63:0] v);
        tag_q.push_back(t);
        exp_q.push_back(v);
    endtask

    task automatic sb_drain();
        while (tag_q.size() > 0) begin
            string       t;
            logic [63:0] v;
            t = tag_q.pop_front();
            v = exp_q.pop_front();
            check(t, observe(t), v);
        end
    endtask

    task automatic drive_ab(input int c);
        enc_a[c] = (ph[c] == 1) || (ph[c] == 2);
        enc_b[c] = (ph[c] >= 2);
    endtask

    // One 4x step per channel (d = +1, -1 or 0), then hold for 5 clocks.
    task automatic step(input int d0, input int d1, input int d2, input bit z1 = 1'b0);
        int d[N];
        d = '{d0, d1, d2};
        @(posedge clk); #1;
        for (int c = 0; c < N; c++) begin
            if (d[c] != 0) begin
                ph[c]   = (ph[c] + d[c] + 4) % 4;
                mpos[c] = mpos[c] + 32'(dir_inv[c] ? -d[c] : d[c]);
                drive_ab(c);
            end
        end
        if (z1) enc_z[1] = 1'b1;
        repeat (4) @(posedge clk);
    endtask

    task automatic settle();
        repeat (10) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clr_pulse(input logic [N-1:0] m);
        @(posedge clk); #1 clr = m;
        @(posedge clk); #1 clr = '0;
        for (int c = 0; c < N; c++) if (m[c]) mpos[c] = '0;
    endtask

    task automatic wait_vv();
        int k;
        k = 0;
        @(negedge clk);
        while (!vel_valid && k < 2000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 2000) check("vv_timeout", 64'(vel_valid), 64'd1);
    endtask

    initial begin
        for (int c = 0; c < N; c++) begin
            ph[c]   = 0;
            mpos[c] = '0;
        end

        // Reset state
        repeat (3) @(posedge clk);
        foreach (tag_q[i]) ;
        sb_push("pos0", 0); sb_push("pos1", 0); sb_push("pos2", 0); sb_push("pos_s0", 0);
        sb_push("err0", 0); sb_push("seen1", 0); sb_push("idxpos1", 0);
        sb_push("vel0", 0); sb_push("vv", 0);
        @(negedge clk);
        sb_drain();
        @(posedge clk); #1 reset = 1'b0;

        // Reset mid-count: 12 steps leave the encoder back at phase 00
        for (int i = 0; i < 12; i++) step(1, 0, 0);
        settle();
        sb_push("pos0", 64'(mpos[0]));
        sb_drain();
        #2 reset = 1'b1;
        #1;
        sb_push("pos0", 0); sb_push("pos_s0", 0);
        sb_drain();
        for (int c = 0; c < N; c++) mpos[c] = '0;
        @(posedge clk); #1 reset = 1'b0;
        step(1, 0, 0);
        settle();
        sb_push("pos0", 64'd1);
        sb_drain();

        // Independent channels, ch2 inverted
        dir_inv = 3'b100;
        clr_pulse(3'b111);
        for (int i = 0; i < 8; i++) step(1, (i < 3) ? -1 : 0, (i < 5) ? 1 : 0);
        settle();
        sb_push("pos0", 64'd8);
        sb_push("pos1", 64'h0000_0000_FFFF_FFFD);
        sb_push("pos2", 64'h0000_0000_FFFF_FFFB);
        sb_push("pos_s0", 64'd8);
        sb_drain();

        // Glitch shorter than the filter, then an illegal double transition
        @(posedge clk); #1 enc_a[0] = ~enc_a[0];
        repeat (2) @(posedge clk);
        #1 enc_a[0] = ~enc_a[0];
        settle();
        sb_push("pos0", 64'(mpos[0])); sb_push("err0", 0);
        sb_drain();
        @(posedge clk); #1;
        ph[0] = (ph[0] + 2) % 4;
        drive_ab(0);
        settle();
        sb_push("pos0", 64'(mpos[0])); sb_push("err0", 1);
        sb_drain();
        clr_pulse(3'b001);
        settle();
        sb_push("pos0", 0); sb_push("err0", 0);
        sb_drain();

        // Wrap on the 8-bit instance
        clr_pulse(3'b111);
        for (int i = 0; i < 255; i++) step(1, 0, 0);
        settle();
        sb_push("pos_s0", 64'h0FF); sb_push("pos0", 64'd255);
        sb_drain();
        step(1, 0, 0);
        settle();
        sb_push("pos_s0", 64'h000); sb_push("pos0", 64'd256);
        sb_drain();
        step(-1, 0, 0);
        settle();
        sb_push("pos_s0", 64'h0FF);
        sb_drain();

        // Index on ch1 coincident with a forward step
        clr_pulse(3'b010);
        settle();
        sb_push("seen1", 0);
        sb_drain();
        for (int i = 0; i < 37; i++) step(0, 1, 0);
        idx_clr_en = 3'b010;
        step(0, 1, 0, 1'b1);
        mpos[1] = 32'd1;
        settle();
        sb_push("idxpos1", 64'd37); sb_push("pos1", 64'd1); sb_push("seen1", 1);
        sb_drain();
        enc_z[1] = 1'b0;
        idx_clr_en = '0;
        settle();
        for (int i = 0; i < 36; i++) step(0, 1, 0);
        step(0, 1, 0, 1'b1);
        settle();
        sb_push("idxpos1", 64'd37); sb_push("pos1", 64'd38);
        sb_drain();
        enc_z[1] = 1'b0;

        // Velocity windows: 120 steps, 40 steps, idle
        wait_vv();
        sb_push("vel0", 64'd120); sb_push("vel_s0", 64'd31); sb_push("vel1", 0);
        sb_push("vv", 1);
        for (int i = 0; i < 120; i++) step(1, 0, 0);
        wait_vv();
        sb_drain();
        @(negedge clk);
        sb_push("vv", 0);
        sb_drain();
        sb_push("vel0", 64'd40); sb_push("vel_s0", 64'd31);
        for (int i = 0; i < 40; i++) step(1, 0, 0);
        wait_vv();
        sb_drain();
        sb_push("vel0", 0); sb_push("vel_s0", 0);
        wait_vv();
        sb_drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
